// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the sequential ALU.
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_DIVU = 3'b011;
    localparam logic [2:0] OP_SLT  = 3'b100;
    localparam logic [2:0] OP_REMU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DONE
    } state_e;

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle over WIDTH cycles.
// prod/quot/rem present the value being written this cycle, so they are final while done=1.
module alu_seq_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,      // 0: multiply, 1: divide
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] prod,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             run_q, run_d;
    logic             op_q, op_d;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   diff;

    // Multiply: acc += ra[0] ? rb : 0, ra >>= 1, rb <<= 1.
    // Divide: ra shifts the dividend out and the quotient in; acc holds the partial remainder.
    always_comb begin
        acc_d     = acc_q;
        ra_d      = ra_q;
        rb_d      = rb_q;
        cnt_d     = cnt_q;
        run_d     = run_q;
        op_d      = op_q;
        rem_shift = '0;
        diff      = '0;
        if (start) begin
            acc_d = '0;
            ra_d  = a;
            rb_d  = b;
            cnt_d = '0;
            run_d = 1'b1;
            op_d  = op;
        end else if (run_q) begin
            if (op_q) begin
                rem_shift = {acc_q, ra_q[WIDTH-1]};
                diff      = rem_shift - {1'b0, rb_q};
                if (diff[WIDTH]) begin
                    acc_d = rem_shift[WIDTH-1:0];
                    ra_d  = {ra_q[WIDTH-2:0], 1'b0};
                end else begin
                    acc_d = diff[WIDTH-1:0];
                    ra_d  = {ra_q[WIDTH-2:0], 1'b1};
                end
            end else begin
                acc_d = acc_q + (ra_q[0] ? rb_q : '0);
                ra_d  = ra_q >> 1;
                rb_d  = rb_q << 1;
            end
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == CntLast) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            ra_q  <= '0;
            rb_q  <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
            op_q  <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ra_q  <= ra_d;
            rb_q  <= rb_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
            op_q  <= op_d;
        end
    end

    assign done = run_q && (cnt_q == CntLast);
    assign prod = acc_d;
    assign quot = ra_d;
    assign rem  = acc_d;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle add/sub/slt, iterative mul/divu/remu, registered result/zero/err.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       alu_con,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             err
);

    state_e           state_q, state_d;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] result_q, res_calc;
    logic             zero_q, err_q, err_calc;
    logic             accept, capture, iter_op, md_start;
    logic             md_done;
    logic [WIDTH-1:0] md_prod, md_quot, md_rem;
    logic             b_is_zero;

    assign accept  = start && (state_q == S_IDLE);
    assign capture = (state_q == S_EXEC) && (state_d == S_DONE);

    // Division by zero never enters the iterative datapath.
    assign md_start = accept && ((alu_con == OP_MUL) ||
                      (((alu_con == OP_DIVU) || (alu_con == OP_REMU)) && (data_b != '0)));

    assign b_is_zero = (b_q == '0);
    assign iter_op   = (op_q == OP_MUL) ||
                       (((op_q == OP_DIVU) || (op_q == OP_REMU)) && !b_is_zero);

    alu_seq_muldiv #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk  (clk),
        .rst_n(rst_n),
        .start(md_start),
        .op   (alu_con != OP_MUL),
        .a    (data_a),
        .b    (data_b),
        .done (md_done),
        .prod (md_prod),
        .quot (md_quot),
        .rem  (md_rem)
    );

    always_comb begin
        res_calc = '0;
        err_calc = 1'b0;
        case (op_q)
            OP_ADD:  res_calc = a_q + b_q;
            OP_SUB:  res_calc = a_q - b_q;
            OP_SLT:  res_calc = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            OP_MUL:  res_calc = md_prod;
            OP_DIVU: begin
                res_calc = b_is_zero ? '1 : md_quot;
                err_calc = b_is_zero;
            end
            OP_REMU: begin
                res_calc = b_is_zero ? a_q : md_rem;
                err_calc = b_is_zero;
            end
            default: begin
                res_calc = '0;
                err_calc = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (start) state_d = S_EXEC;
            S_EXEC: if (!iter_op || md_done) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                op_q <= alu_con;
                a_q  <= data_a;
                b_q  <= data_b;
            end
            if (capture) begin
                result_q <= res_calc;
                zero_q   <= (res_calc == '0);
                err_q    <= err_calc;
            end
        end
    end

    assign result = result_q;
    assign zero   = zero_q;
    assign err    = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=32): latency, results, flags, ignored starts, reset abort.
module tb_alu_seq;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [2:0]   alu_con;
    logic [W-1:0] data_a, data_b;
    logic         busy, done, zero, err;
    logic [W-1:0] result;

    int checks = 0;
    int errors = 0;

    alu_seq #(
        .WIDTH(W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .alu_con(alu_con),
        .data_a (data_a),
        .data_b (data_b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .zero   (zero),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Accepting edge counts as edge 1; lat is the edge after which done is first seen.
    // stray > 0 pulses start with different operands that many edges into the operation.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_res,
                          input logic exp_zero, input logic exp_err, input int exp_lat,
                          input int stray);
        int n;
        @(negedge clk);
        start   = 1'b1;
        alu_con = op;
        data_a  = a;
        data_b  = b;
        @(posedge clk);
        n = 1;
        @(negedge clk);
        start   = 1'b0;
        alu_con = 3'b110;
        data_a  = 32'hDEAD_BEEF;
        data_b  = 32'h0000_0000;
        check({tag, "_busy"}, busy, 1'b1);
        while (!done && n < 100) begin
            if (n == stray) begin
                start   = 1'b1;
                alu_con = 3'b000;
                data_a  = 32'h1111_1111;
                data_b  = 32'h2222_2222;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check({tag, "_lat"}, n, exp_lat);
        check({tag, "_res"}, result, exp_res);
        check({tag, "_zero"}, zero, exp_zero);
        check({tag, "_err"}, err, exp_err);
        // Start in the DONE cycle must be ignored.
        start   = 1'b1;
        alu_con = 3'b000;
        data_a  = 32'h5;
        data_b  = 32'h5;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check({tag, "_idle"}, {busy, done}, 2'b00);
        check({tag, "_hold"}, result, exp_res);
    endtask

    initial begin
        int seen_done;
        rst_n   = 1'b0;
        start   = 1'b0;
        alu_con = 3'b000;
        data_a  = '0;
        data_b  = '0;
        repeat (2) @(negedge clk);
        check("rst_outs", {busy, done, zero, err}, 4'b0000);
        check("rst_res", result, 32'h0);
        rst_n = 1'b1;

        run_op("add_wrap", 3'b000, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1'b0, 2, 0);
        run_op("sub", 3'b001, 32'h5, 32'h7, 32'hFFFF_FFFE, 1'b0, 1'b0, 2, 0);
        run_op("mul", 3'b010, 32'h0001_0003, 32'h5, 32'h0005_000F, 1'b0, 1'b0, 33, 0);
        run_op("divu", 3'b011, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 33, 0);
        run_op("remu", 3'b101, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0, 33, 0);
        run_op("divu_b0", 3'b011, 32'd100, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b1, 2, 0);
        run_op("remu_b0", 3'b101, 32'd100, 32'd0, 32'd100, 1'b0, 1'b1, 2, 0);
        run_op("slt_neg", 3'b100, 32'hFFFF_FFFE, 32'h1, 32'h1, 1'b0, 1'b0, 2, 0);
        run_op("slt_swap", 3'b100, 32'h1, 32'hFFFF_FFFE, 32'h0, 1'b1, 1'b0, 2, 0);
        run_op("ill_111", 3'b111, 32'h1234, 32'h5678, 32'h0, 1'b1, 1'b1, 2, 0);
        run_op("ill_110", 3'b110, 32'h1, 32'h1, 32'h0, 1'b1, 1'b1, 2, 0);
        run_op("mul_stray", 3'b010, 32'h0000_1234, 32'h10, 32'h0001_2340, 1'b0, 1'b0, 33, 5);
        run_op("divu_big", 3'b011, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 1'b0, 1'b0, 33, 0);

        // Abort a divu mid-operation with reset.
        @(negedge clk);
        start   = 1'b1;
        alu_con = 3'b011;
        data_a  = 32'd100;
        data_b  = 32'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_outs", {busy, done, zero, err}, 4'b0000);
        check("abort_res", result, 32'h0);
        seen_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        check("abort_nodone", seen_done, 0);
        run_op("add_after", 3'b000, 32'h0000_00FF, 32'h0000_0101, 32'h0000_0200, 1'b0, 1'b0,
               2, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 32, sets the operand and result width in bits (legal range 8..64).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle request; sampled only while busy=0.
REQ-005 alu_con  input  3  opcode: 000 add, 001 sub, 010 mul (low WIDTH bits), 011 divu (quotient), 100 slt (signed), 101 remu, 110/111 illegal.
REQ-006 data_a  input  WIDTH  operand A, captured on the accepted start.
REQ-007 data_b  input  WIDTH  operand B, captured on the accepted start.
REQ-008 busy  output  1  high from the cycle after the accepted start until done.
REQ-009 done  output  1  one-cycle pulse when result, zero and err are valid.
REQ-010 result  output  WIDTH  registered result, held until the next done.
REQ-011 zero  output  1  registered; 1 when result == 0, updated with done.
REQ-012 err  output  1  registered; 1 on divide-by-zero or illegal opcode, updated with done.

Function
REQ-013 A start is accepted when start=1 and busy=0; the block captures alu_con, data_a and data_b in that edge.
REQ-014 The FSM has three states: IDLE -> EXEC on accepted start; EXEC -> DONE when the operation completes; DONE -> IDLE unconditionally after one cycle.
REQ-015 done=1 only in DONE; busy=1 in EXEC and DONE.
REQ-016 add, sub, slt, illegal opcode and any divide-by-zero spend 1 cycle in EXEC, so done rises 2 clk edges after the accepting edge.
REQ-017 mul uses an iterative shift-add over WIDTH cycles in EXEC, one partial product bit per cycle; done rises WIDTH+1 edges after the accepting edge.
REQ-018 divu and remu use an iterative restoring divide over WIDTH cycles in EXEC; done rises WIDTH+1 edges after the accepting edge.
REQ-019 An iteration counter of width clog2(WIDTH)+1 is cleared on accept and ends EXEC when it reaches WIDTH.
REQ-020 add and sub wrap modulo 2^WIDTH; carry and overflow are discarded.
REQ-021 slt compares two's-complement signed values; result = 1 if A<B, else 0 (zero-extended).
REQ-022 mul result = low WIDTH bits of the unsigned product, which equals the signed low half.
REQ-023 divu/remu with B=0: result = all-ones for divu, result = A for remu, err=1.
REQ-024 Illegal opcode: result = 0, zero = 1, err = 1.
REQ-025 For all legal opcodes with B!=0, err = 0.
REQ-026 start while busy=1 is ignored; operands and opcode do not change mid-operation.
REQ-027 start asserted in the DONE cycle is ignored; a new start is accepted from IDLE only.
REQ-028 Input changes after the accepting edge do not affect the result.

Reset
REQ-029 While rst_n=0 the FSM is in IDLE, and busy=0, done=0, result=0, zero=0, err=0, counter=0.
REQ-030 Reset asserted mid-operation aborts it immediately; no done is produced for the aborted operation.
REQ-031 After rst_n deasserts, the first clock edge with start=1 is accepted normally.

Structure
REQ-032 Package alu_pkg holds the opcode localparams (OP_ADD..OP_REMU) and the state enum (S_IDLE, S_EXEC, S_DONE).
REQ-033 The iterative multiply/divide datapath (accumulator, shift registers, counter) is one sub-module, alu_seq_muldiv, with start/op/a/b inputs and done/prod/quot/rem outputs.
REQ-034 The add/sub/slt path stays combinational in alu_seq and is registered into result in EXEC.

Verification (WIDTH=32)
REQ-035 add: A=0xFFFFFFFF, B=1 -> done after 2 edges, result=0, zero=1, err=0.
REQ-036 mul: A=0x0001_0003, B=0x0000_0005 -> done at edge 33, result=0x0005_000F; busy high for 32 cycles then DONE.
REQ-037 divu/remu: A=100, B=7 -> quotient 14 and remainder 2, each done at edge 33; with B=0 -> divu result 0xFFFFFFFF, remu result 100, err=1, done at edge 2.
REQ-038 slt: A=0xFFFFFFFE (-2), B=1 -> result 1; swap the operands -> result 0.
REQ-039 Illegal opcode 3'b111 -> result 0, zero=1, err=1; start pulsed during a mul is ignored, and the mul result is unchanged.
REQ-040 rst_n pulled low at cycle 10 of a divu -> outputs reset at once, no done; a new add started after reset completes correctly.
